// File: rtl/f_fetch_unit_pkg.sv
// f_fetch_unit_pkg
// Shared definitions for the fetch stage: next-PC operation encoding,
// reset/handler addresses, the legal instruction-memory window and a
// helper that classifies a fetch address as an address error (AdEL).
package f_fetch_unit_pkg;

    // Next-PC operation requested by the instruction currently in D
    typedef enum logic [1:0] {
        npc_seq = 2'd0,
        npc_br  = 2'd1,
        npc_j   = 2'd2,
        npc_jr  = 2'd3
    } npc_op_t;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam logic [31:0] IM_TOP    = 32'h0000_6ffc;

    // A fetch is illegal if it is misaligned or falls outside the
    // instruction-memory window (IM_TOP is inclusive)
    function automatic logic is_adel(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_TOP);
    endfunction

endpackage

// File: rtl/f_fetch_unit_if.sv
// f_fetch_unit_if
// Bundles every non-clock/reset signal of the fetch stage.
//   master : the fetch unit (drives f_pc and the F/D register outputs)
//   slave  : the rest of the pipeline / instruction memory
// D-stage control : stall, isBr, npcOp, d_imm16, d_imm26, d_rs
// Redirects       : req, eret, epc
// Instr memory    : f_pc (address), f_instr (combinational read data)
// F/D register    : d_instr, d_pc, d_bd, d_excAdEL
interface f_fetch_unit_if;
    import f_fetch_unit_pkg::*;

    logic        stall;
    logic        isBr;
    npc_op_t     npcOp;
    logic [15:0] d_imm16;
    logic [25:0] d_imm26;
    logic [31:0] d_rs;
    logic        req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic        d_bd;
    logic        d_excAdEL;

    modport master (
        input  stall, isBr, npcOp, d_imm16, d_imm26, d_rs,
        input  req, eret, epc, f_instr,
        output f_pc, d_instr, d_pc, d_bd, d_excAdEL
    );

    modport slave (
        output stall, isBr, npcOp, d_imm16, d_imm26, d_rs,
        output req, eret, epc, f_instr,
        input  f_pc, d_instr, d_pc, d_bd, d_excAdEL
    );

endinterface

// File: rtl/f_fetch_unit_npc.sv
// f_fetch_unit_npc
// Combinational next-PC selection for the fetch stage.
// Inputs : f_pc, d_pc, d_imm16, d_imm26, d_rs, isBr, npcOp, req, eret, epc
// Outputs: npc (PC to load on an unstalled or redirected edge),
//          bd  (the word fetched now sits in a branch delay slot)
// Stall is not handled here; the PC register decides whether to load npc.
module f_fetch_unit_npc
    import f_fetch_unit_pkg::*;
(
    input  logic [31:0] f_pc,
    input  logic [31:0] d_pc,
    input  logic [15:0] d_imm16,
    input  logic [25:0] d_imm26,
    input  logic [31:0] d_rs,
    input  logic        isBr,
    input  npc_op_t     npcOp,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] npc,
    output logic        bd
);

    logic [31:0] d_pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;

    // Targets are relative to the control-transfer instruction in D
    assign d_pc_plus4 = d_pc + 32'd4;
    assign br_target  = d_pc_plus4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
    assign j_target   = {d_pc_plus4[31:28], d_imm26, 2'b00};

    // Any non-sequential op in D means the word being fetched now is its
    // delay slot, whether or not the branch is taken
    assign bd = (npcOp != npc_seq);

    // Redirects first, then the D-stage control transfer, else sequential
    always_comb begin
        npc = f_pc + 32'd4;
        if (req) begin
            npc = EXC_ENTRY;
        end else if (eret) begin
            npc = epc;
        end else begin
            unique case (npcOp)
                npc_br:  npc = isBr ? br_target : f_pc + 32'd4;
                npc_j:   npc = j_target;
                npc_jr:  npc = d_rs;
                default: npc = f_pc + 32'd4;
            endcase
        end
    end

endmodule

// File: rtl/f_fetch_unit.sv
// f_fetch_unit
// Fetch stage and F/D pipeline register of the five-stage MIPS pipeline.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : f_fetch_unit_if.master (D-stage control, redirects, instruction
//           memory address/data, F/D register outputs)
// Owns the PC register, the F/D register and fetch address-error detection.
module f_fetch_unit
    import f_fetch_unit_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    f_fetch_unit_if.master bus
);

    logic [31:0] pc_q;
    logic [31:0] npc;
    logic        slot_bd;
    logic        fetch_adel;
    logic        redirect;
    logic [31:0] d_instr_q;
    logic [31:0] d_pc_q;
    logic        d_bd_q;
    logic        d_adel_q;

    f_fetch_unit_npc u_npc (
        .f_pc    (pc_q),
        .d_pc    (d_pc_q),
        .d_imm16 (bus.d_imm16),
        .d_imm26 (bus.d_imm26),
        .d_rs    (bus.d_rs),
        .isBr    (bus.isBr),
        .npcOp   (bus.npcOp),
        .req     (bus.req),
        .eret    (bus.eret),
        .epc     (bus.epc),
        .npc     (npc),
        .bd      (slot_bd)
    );

    // req and eret win over stall: they redirect and flush on this edge
    assign redirect   = bus.req | bus.eret;
    assign fetch_adel = is_adel(pc_q);

    // PC register: holds only on a plain stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else if (redirect || !bus.stall) begin
            pc_q <= npc;
        end
    end

    // F/D register: a redirect turns D into a bubble (eret has no delay
    // slot, so the word fetched alongside it is dropped); a bad fetch
    // still advances but carries a nop and the AdEL flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_instr_q <= '0;
            d_pc_q    <= '0;
            d_bd_q    <= 1'b0;
            d_adel_q  <= 1'b0;
        end else if (redirect) begin
            d_instr_q <= '0;
            d_pc_q    <= '0;
            d_bd_q    <= 1'b0;
            d_adel_q  <= 1'b0;
        end else if (!bus.stall) begin
            d_instr_q <= fetch_adel ? 32'h0 : bus.f_instr;
            d_pc_q    <= pc_q;
            d_bd_q    <= slot_bd;
            d_adel_q  <= fetch_adel;
        end
    end

    assign bus.f_pc      = pc_q;
    assign bus.d_instr   = d_instr_q;
    assign bus.d_pc      = d_pc_q;
    assign bus.d_bd      = d_bd_q;
    assign bus.d_excAdEL = d_adel_q;

endmodule
